// File: rtl/jt49_stereo_mix.sv
// jt49_stereo_mix: per-sample gain/pan MAC over PSG channels A/B/C with optional DC removal, stereo out
module jt49_stereo_mix #(
  parameter int DCW = 8,
  parameter bit DC_BYPASS = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               sample,
  input  logic [7:0]         A,
  input  logic [7:0]         B,
  input  logic [7:0]         C,
  input  logic [11:0]        gain,
  input  logic [5:0]         pan,
  output logic signed [15:0] left,
  output logic signed [15:0] right,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);
  localparam int AW = 14 + DCW;
  typedef enum logic [2:0] {IDLE, CHA, CHB, CHC, DCS} state_t;
  state_t             state_q, state_d;
  logic [23:0]        lvl_q, lvl_d;
  logic [11:0]        gain_q, gain_d;
  logic [5:0]         pan_q, pan_d;
  logic [13:0]        accl_q, accl_d, accr_q, accr_d;
  logic [AW-1:0]      avgl_q, avgl_d, avgr_q, avgr_d;
  logic signed [15:0] left_q, left_d, right_q, right_d;
  logic               out_valid_q, out_valid_d, busy_q, busy_d, overrun_q, overrun_d;
  logic [7:0]         lvl;
  logic [3:0]         g;
  logic [1:0]         p;
  logic [11:0]        prod;
  // next-state: latch a sample in IDLE, one channel MAC per enabled cycle, then DC stage and output
  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    gain_d      = gain_q;
    pan_d       = pan_q;
    accl_d      = accl_q;
    accr_d      = accr_q;
    avgl_d      = avgl_q;
    avgr_d      = avgr_q;
    left_d      = left_q;
    right_d     = right_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q | (clk_en & sample & (state_q != IDLE));
    lvl  = state_q == CHA ? lvl_q[7:0]  : state_q == CHB ? lvl_q[15:8]  : lvl_q[23:16];
    g    = state_q == CHA ? gain_q[3:0] : state_q == CHB ? gain_q[7:4]  : gain_q[11:8];
    p    = state_q == CHA ? pan_q[1:0]  : state_q == CHB ? pan_q[3:2]   : pan_q[5:4];
    prod = 12'(lvl) * 12'(g);
    if (clk_en) begin
      unique case (state_q)
        IDLE: if (sample) begin
          lvl_d   = {C, B, A};
          gain_d  = gain;
          pan_d   = pan;
          accl_d  = '0;
          accr_d  = '0;
          busy_d  = 1'b1;
          state_d = CHA;
        end
        CHA, CHB, CHC: begin
          accl_d  = accl_q + (p[0] ? 14'(prod) : 14'd0);
          accr_d  = accr_q + (p[1] ? 14'(prod) : 14'd0);
          state_d = state_q == CHA ? CHB : state_q == CHB ? CHC : DCS;
        end
        DCS: begin
          if (DC_BYPASS) begin
            left_d  = {1'b0, accl_q, 1'b0};
            right_d = {1'b0, accr_q, 1'b0};
          end else begin
            left_d  = ({2'b0, accl_q} - {2'b0, avgl_q[AW-1:DCW]}) << 1;
            right_d = ({2'b0, accr_q} - {2'b0, avgr_q[AW-1:DCW]}) << 1;
            avgl_d  = avgl_q + AW'(accl_q) - (avgl_q >> DCW);
            avgr_d  = avgr_q + AW'(accr_q) - (avgr_q >> DCW);
          end
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state registers; out_valid is reloaded every clk so it never outlives one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lvl_q       <= '0;
      gain_q      <= '0;
      pan_q       <= '0;
      accl_q      <= '0;
      accr_q      <= '0;
      avgl_q      <= '0;
      avgr_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      gain_q      <= gain_d;
      pan_q       <= pan_d;
      accl_q      <= accl_d;
      accr_q      <= accr_d;
      avgl_q      <= avgl_d;
      avgr_q      <= avgr_d;
      left_q      <= left_d;
      right_q     <= right_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end
  assign left      = left_q;
  assign right     = right_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_jt49_stereo_mix.sv
// tb_jt49_stereo_mix: directed checks of bypass and DC-removal mixer instances
module tb_jt49_stereo_mix;
  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, sample = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;
  logic [11:0] gain = '0;
  logic [5:0] pan = '0;
  logic signed [15:0] byp_left, byp_right, dc_left, dc_right;
  logic byp_valid, byp_busy, byp_ovr, dc_valid, dc_busy, dc_ovr;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  jt49_stereo_mix #(.DCW(8), .DC_BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sample(sample), .A(a), .B(b), .C(c),
    .gain(gain), .pan(pan), .left(byp_left), .right(byp_right), .out_valid(byp_valid),
    .busy(byp_busy), .overrun(byp_ovr));
  jt49_stereo_mix #(.DCW(8), .DC_BYPASS(1'b0)) u_dc (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sample(sample), .A(a), .B(b), .C(c),
    .gain(gain), .pan(pan), .left(dc_left), .right(dc_right), .out_valid(dc_valid),
    .busy(dc_busy), .overrun(dc_ovr));
  task automatic set_in(input logic [7:0] ia, ib, ic, input logic [11:0] ig, input logic [5:0] ip);
    a = ia; b = ib; c = ic; gain = ig; pan = ip;
  endtask
  task automatic fire(output int k);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      if (byp_valid) begin
        k = i;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({byp_left, byp_right, byp_valid, byp_busy, byp_ovr} !== 35'd0) begin
      errors++;
      $display("FAIL reset_byp: got %h want 0", {byp_left, byp_right, byp_valid, byp_busy, byp_ovr});
    end
    checks++;
    if ({dc_left, dc_right, dc_valid, dc_busy, dc_ovr} !== 35'd0) begin
      errors++;
      $display("FAIL reset_dc: got %h want 0", {dc_left, dc_right, dc_valid, dc_busy, dc_ovr});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single();
    set_in(8'd255, 8'd0, 8'd0, 12'h00f, 6'b000011);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (byp_busy !== 1'b1 || byp_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_busy%0d: got busy=%b valid=%b want busy=1 valid=0", i, byp_busy, byp_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (byp_valid !== 1'b1 || byp_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_valid: got valid=%b busy=%b want valid=1 busy=0", byp_valid, byp_busy);
    end
    checks++;
    if (byp_left !== 16'sd7650 || byp_right !== 16'sd7650) begin
      errors++;
      $display("FAIL single_value: got %0d/%0d want 7650/7650", byp_left, byp_right);
    end
    @(negedge clk);
    checks++;
    if (byp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: got valid=%b want 0", byp_valid);
    end
  endtask
  task automatic test_mix();
    int k;
    set_in(8'd100, 8'd50, 8'd10, {4'd10, 4'd4, 4'd2}, {2'd3, 2'd2, 2'd1});
    fire(k);
    checks++;
    if (k != 5 || byp_left !== 16'sd600 || byp_right !== 16'sd600) begin
      errors++;
      $display("FAIL mix_all: got k=%0d %0d/%0d want k=5 600/600", k, byp_left, byp_right);
    end
    set_in(8'd100, 8'd50, 8'd10, {4'd10, 4'd4, 4'd2}, {2'd0, 2'd2, 2'd1});
    fire(k);
    checks++;
    if (k != 5 || byp_left !== 16'sd400 || byp_right !== 16'sd400) begin
      errors++;
      $display("FAIL mix_pc0: got k=%0d %0d/%0d want k=5 400/400", k, byp_left, byp_right);
    end
    set_in(8'd100, 8'd50, 8'd10, {4'd10, 4'd4, 4'd0}, 6'b111111);
    fire(k);
    checks++;
    if (k != 5 || byp_left !== 16'sd600 || byp_right !== 16'sd600) begin
      errors++;
      $display("FAIL mix_gmute: got k=%0d %0d/%0d want k=5 600/600", k, byp_left, byp_right);
    end
    set_in(8'd255, 8'd255, 8'd255, 12'hfff, {2'd1, 2'd2, 2'd3});
    fire(k);
    checks++;
    if (k != 5 || byp_left !== 16'sd15300 || byp_right !== 16'sd15300) begin
      errors++;
      $display("FAIL mix_max: got k=%0d %0d/%0d want k=5 15300/15300", k, byp_left, byp_right);
    end
  endtask
  task automatic test_overrun();
    int cnt = 0;
    logic signed [15:0] lv = 16'sd0, rv = 16'sd0;
    do_reset();
    checks++;
    if (byp_ovr !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got %b want 0", byp_ovr);
    end
    set_in(8'd10, 8'd0, 8'd0, 12'h001, 6'b000001);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    set_in(8'd200, 8'd0, 8'd0, 12'h00f, 6'b000011);
    @(negedge clk);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (byp_valid) begin
        cnt++;
        lv = byp_left;
        rv = byp_right;
      end
      @(negedge clk);
    end
    checks++;
    if (cnt != 1) begin
      errors++;
      $display("FAIL ovr_count: got %0d pulses want 1", cnt);
    end
    checks++;
    if (lv !== 16'sd20 || rv !== 16'sd0) begin
      errors++;
      $display("FAIL ovr_value: got %0d/%0d want 20/0", lv, rv);
    end
    checks++;
    if (byp_ovr !== 1'b1 || dc_ovr !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flag: got %b/%b want 1/1", byp_ovr, dc_ovr);
    end
  endtask
  task automatic test_clk_en();
    int k = 2;
    set_in(8'd255, 8'd0, 8'd0, 12'h00f, 6'b000011);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    @(negedge clk);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (byp_valid !== 1'b0 || byp_busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b busy=%b want 0/1", i, byp_valid, byp_busy);
      end
    end
    clk_en = 1'b1;
    k = 5;
    while (!byp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL stall_latency: got %0d want 8", k);
    end
    checks++;
    if (byp_left !== 16'sd7650 || byp_right !== 16'sd7650) begin
      errors++;
      $display("FAIL stall_value: got %0d/%0d want 7650/7650", byp_left, byp_right);
    end
    clk_en = 1'b0;
    @(negedge clk);
    checks++;
    if (byp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_pulse: got valid=%b want 0", byp_valid);
    end
    clk_en = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    int k, cnt = 0;
    set_in(8'd255, 8'd0, 8'd0, 12'h00f, 6'b000011);
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byp_left, byp_right, byp_valid, byp_busy, byp_ovr, dc_left, dc_right, dc_valid, dc_busy, dc_ovr} !== 70'd0) begin
      errors++;
      $display("FAIL rstmid_zero: got %h/%h want 0/0", byp_left, dc_left);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (byp_valid || dc_valid) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL rstmid_novalid: got %0d pulses want 0", cnt);
    end
    fire(k);
    checks++;
    if (k != 5 || dc_left !== 16'sd7650 || dc_right !== 16'sd7650 || byp_left !== 16'sd7650) begin
      errors++;
      $display("FAIL rstmid_after: got k=%0d dc=%0d/%0d byp=%0d want 5 7650", k, dc_left, dc_right, byp_left);
    end
  endtask
  task automatic test_dc();
    int k, tmo = 0, nz = 0;
    do_reset();
    set_in(8'd255, 8'd0, 8'd0, 12'h00f, 6'b000011);
    fire(k);
    checks++;
    if (k != 5 || dc_left !== 16'sd7650 || dc_right !== 16'sd7650) begin
      errors++;
      $display("FAIL dc_first: got k=%0d %0d/%0d want 5 7650/7650", k, dc_left, dc_right);
    end
    fire(k);
    checks++;
    if (k != 5 || dc_left !== 16'sd7622 || dc_right !== 16'sd7622) begin
      errors++;
      $display("FAIL dc_second: got k=%0d %0d/%0d want 5 7622/7622", k, dc_left, dc_right);
    end
    for (int n = 3; n <= 4096; n++) begin
      fire(k);
      if (k != 5) tmo++;
    end
    checks++;
    if (tmo != 0) begin
      errors++;
      $display("FAIL dc_timeout: got %0d late samples want 0", tmo);
    end
    checks++;
    if (dc_left !== 16'sd0 || dc_right !== 16'sd0) begin
      errors++;
      $display("FAIL dc_settled: got %0d/%0d want 0/0", dc_left, dc_right);
    end
    for (int n = 0; n < 4; n++) begin
      fire(k);
      if (k != 5 || dc_left !== 16'sd0 || dc_right !== 16'sd0) nz++;
    end
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL dc_stays0: got %0d nonzero want 0", nz);
    end
    set_in(8'd0, 8'd0, 8'd0, 12'h00f, 6'b000011);
    fire(k);
    checks++;
    if (k != 5 || dc_left !== -16'sd7650 || dc_right !== -16'sd7650) begin
      errors++;
      $display("FAIL dc_step: got k=%0d %0d/%0d want 5 -7650/-7650", k, dc_left, dc_right);
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_mix();
    test_overrun();
    test_clk_en();
    test_reset_mid();
    test_dc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
